// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue decoder: ALU op codes, RV32 opcode
// constants, buffer state encoding and the decoded-op record.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_SLL = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SRL = 4'b0100,
    ALU_SRA = 4'b0101,
    ALU_OR  = 4'b0110,
    ALU_AND = 4'b0111,
    ALU_BLT = 4'b1000,
    ALU_BGE = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  typedef struct packed {
    alu_op_e           ctrl;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              illegal;
  } issue_op_t;

endpackage

// File: rtl/alu_imm_gen.sv
// Immediate extraction for the ALU issue decoder. Purely combinational:
// produces the sign-extended I/S immediates, the U immediate and the
// zero-extended shift amount from the upper instruction bits.
module alu_imm_gen
  import alu_pkg::*;
(
  input  logic [31:7]       instr_bits,
  output logic [DATA_W-1:0] imm_itype,
  output logic [DATA_W-1:0] imm_stype,
  output logic [DATA_W-1:0] imm_utype,
  output logic [DATA_W-1:0] imm_shamt
);

  assign imm_itype = {{20{instr_bits[31]}}, instr_bits[31:20]};
  assign imm_stype = {{20{instr_bits[31]}}, instr_bits[31:25], instr_bits[11:7]};
  assign imm_utype = {instr_bits[31:12], 12'b0};
  assign imm_shamt = {27'b0, instr_bits[24:20]};

endmodule

// File: rtl/alu_issue_decoder.sv
// ALU issue decoder: decodes an RV32 instruction into an ALU op code and
// two operands, and buffers decoded ops in an output register plus one
// skid register so that ready_o can be fully registered.
// Optional feature macro: RV_BRANCH_CMP_EN -- when defined, BLT/BGE branches
// emit the dedicated compare codes; otherwise every legal branch emits SUB.
module alu_issue_decoder
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [3:0]      ALUCtrl_o,
  output logic [XLEN-1:0] data1_o,
  output logic [XLEN-1:0] data2_o,
  output logic            illegal_o
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   imm_itype;
  logic [XLEN-1:0]   imm_stype;
  logic [XLEN-1:0]   imm_utype;
  logic [XLEN-1:0]   imm_shamt;
  alu_op_e           dec_op;
  logic [XLEN-1:0]   dec_d1;
  logic [XLEN-1:0]   dec_d2;
  logic              dec_bad;
  issue_op_t         dec;

  state_e            state;
  issue_op_t         out_q;
  issue_op_t         skid_q;
  logic              valid_q;
  logic              ready_q;
  logic              accept;
  logic              drain;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  alu_imm_gen u_imm_gen (
    .instr_bits (instr_i[31:7]),
    .imm_itype  (imm_itype),
    .imm_stype  (imm_stype),
    .imm_utype  (imm_utype),
    .imm_shamt  (imm_shamt)
  );

  // Decode opcode/funct3 into an ALU op and operands; unsupported encodings collapse to a zeroed ADD flagged illegal.
  always_comb begin
    dec_bad = 1'b0;
    dec_op  = ALU_ADD;
    dec_d1  = rs1_data_i;
    dec_d2  = rs2_data_i;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          3'b000:  dec_op = instr_i[30] ? ALU_SUB : ALU_ADD;
          3'b001:  dec_op = ALU_SLL;
          3'b100:  dec_op = ALU_XOR;
          3'b101:  dec_op = instr_i[30] ? ALU_SRA : ALU_SRL;
          3'b110:  dec_op = ALU_OR;
          3'b111:  dec_op = ALU_AND;
          default: dec_bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_d2 = imm_itype;
        case (funct3)
          3'b000:  dec_op = ALU_ADD;
          3'b001: begin
            dec_op = ALU_SLL;
            dec_d2 = imm_shamt;
          end
          3'b100:  dec_op = ALU_XOR;
          3'b101: begin
            dec_op = instr_i[30] ? ALU_SRA : ALU_SRL;
            dec_d2 = imm_shamt;
          end
          3'b110:  dec_op = ALU_OR;
          3'b111:  dec_op = ALU_AND;
          default: dec_bad = 1'b1;
        endcase
      end
      OPC_LOAD:  dec_d2 = imm_itype;
      OPC_STORE: dec_d2 = imm_stype;
      OPC_LUI: begin
        dec_d1 = '0;
        dec_d2 = imm_utype;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: dec_op = ALU_SUB;
`ifdef RV_BRANCH_CMP_EN
          3'b100:  dec_op = ALU_BLT;
          3'b101:  dec_op = ALU_BGE;
`else
          3'b100, 3'b101: dec_op = ALU_SUB;
`endif
          default: dec_bad = 1'b1;
        endcase
      end
      default: dec_bad = 1'b1;
    endcase
    if (dec_bad) begin
      dec_op = ALU_ADD;
      dec_d1 = '0;
      dec_d2 = '0;
    end
    dec.ctrl    = dec_op;
    dec.data1   = dec_d1;
    dec.data2   = dec_d2;
    dec.illegal = dec_bad;
  end

  assign accept = valid_i & ready_q;
  assign drain  = valid_q & ready_i;

  // Output/skid buffer FSM; valid and ready are registered alongside the state, and flush overrides any handshake.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state   <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          ready_q <= 1'b1;
          if (accept) begin
            out_q   <= dec;
            valid_q <= 1'b1;
            state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_q <= dec;
          end else if (accept) begin
            skid_q  <= dec;
            ready_q <= 1'b0;
            state   <= ST_FULL;
          end else if (drain) begin
            valid_q <= 1'b0;
            state   <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            out_q   <= skid_q;
            ready_q <= 1'b1;
            state   <= ST_ONE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_EMPTY;
        end
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign ALUCtrl_o = out_q.ctrl;
  assign data1_o   = out_q.data1;
  assign data2_o   = out_q.data2;
  assign illegal_o = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Testbench for alu_issue_decoder: a table of instruction vectors with
// hand-derived expected decodes, a scoreboard that checks every op leaving
// the buffer in order, and directed sequences for stall, flush and reset.
module tb_alu_issue_decoder;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        ill;
  } vec_t;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        ill;
  } exp_t;

`ifdef RV_BRANCH_CMP_EN
  localparam logic [3:0] EXP_BLT = 4'b1000;
  localparam logic [3:0] EXP_BGE = 4'b1001;
`else
  localparam logic [3:0] EXP_BLT = 4'b0001;
  localparam logic [3:0] EXP_BGE = 4'b0001;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] instr;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        valid_out;
  logic        ready_in;
  logic [3:0]  alu_ctrl;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        illegal;

  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vecs[$];
  exp_t        sb[$];
  exp_t        cur_exp;

  alu_issue_decoder #(.XLEN(32)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .flush_i    (flush),
    .valid_i    (valid_in),
    .ready_o    (ready_out),
    .instr_i    (instr),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .valid_o    (valid_out),
    .ready_i    (ready_in),
    .ALUCtrl_o  (alu_ctrl),
    .data1_o    (data1),
    .data2_o    (data2),
    .illegal_o  (illegal)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Scoreboard: observes handshakes mid-cycle; drains pop and compare, accepts push the expected decode.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (valid_out && ready_in) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("[TB] FAIL ghost_op: drained ctrl=%h d1=%h d2=%h ill=%b with nothing outstanding", alu_ctrl, data1, data2, illegal);
        end else begin
          e = sb.pop_front();
          if ({alu_ctrl, data1, data2, illegal} !== e) begin
            n_err++;
            $display("[TB] FAIL sb_pop: got ctrl=%h d1=%h d2=%h ill=%b, expected ctrl=%h d1=%h d2=%h ill=%b", alu_ctrl, data1, data2, illegal, e.ctrl, e.d1, e.d2, e.ill);
          end
        end
      end
      if (valid_in && ready_out) sb.push_back(cur_exp);
    end
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    instr    = v.instr;
    rs1      = v.rs1;
    rs2      = v.rs2;
    cur_exp  = '{ctrl: v.ctrl, d1: v.d1, d2: v.d2, ill: v.ill};
    valid_in = 1'b1;
  endtask

  task automatic add_vec(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, input logic [31:0] d1, input logic [31:0] d2, input logic il);
    vec_t v;
    v.instr = i; v.rs1 = a; v.rs2 = b; v.ctrl = c; v.d1 = d1; v.d2 = d2; v.ill = il;
    vecs.push_back(v);
  endtask

  task automatic drain_all();
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  initial begin
    add_vec(32'h40208033, 32'd7,        32'd3,      4'b0001, 32'd7,        32'd3,        1'b0); // sub
    add_vec(32'hFFF00093, 32'd5,        32'h99,     4'b0000, 32'd5,        32'hFFFFFFFF, 1'b0); // addi -1
    add_vec(32'h4030D093, 32'h80000000, 32'h99,     4'b0101, 32'h80000000, 32'd3,        1'b0); // srai 3
    add_vec(32'h0020C063, 32'h11,       32'h22,     EXP_BLT, 32'h11,       32'h22,       1'b0); // blt
    add_vec(32'h0020A033, 32'h11,       32'h22,     4'b0000, 32'h0,        32'h0,        1'b1); // slt
    add_vec(32'h002081B3, 32'd100,      32'd23,     4'b0000, 32'd100,      32'd23,       1'b0); // add
    add_vec(32'h0020C1B3, 32'hF0F0,     32'h0FF0,   4'b0011, 32'hF0F0,     32'h0FF0,     1'b0); // xor
    add_vec(32'h0020E1B3, 32'h1,        32'h2,      4'b0110, 32'h1,        32'h2,        1'b0); // or
    add_vec(32'h0020F1B3, 32'h3,        32'h4,      4'b0111, 32'h3,        32'h4,        1'b0); // and
    add_vec(32'h002091B3, 32'h5,        32'h6,      4'b0010, 32'h5,        32'h6,        1'b0); // sll
    add_vec(32'h0020D1B3, 32'h7,        32'h8,      4'b0100, 32'h7,        32'h8,        1'b0); // srl
    add_vec(32'h4020D1B3, 32'h9,        32'hA,      4'b0101, 32'h9,        32'hA,        1'b0); // sra
    add_vec(32'h00812083, 32'h1000,     32'h5,      4'b0000, 32'h1000,     32'h8,        1'b0); // lw 8
    add_vec(32'hFE20AE23, 32'h2000,     32'h77,     4'b0000, 32'h2000,     32'hFFFFFFFC, 1'b0); // sw -4
    add_vec(32'h123450B7, 32'hDEAD,     32'hBEEF,   4'b0000, 32'h0,        32'h12345000, 1'b0); // lui
    add_vec(32'h00208063, 32'h1,        32'h2,      4'b0001, 32'h1,        32'h2,        1'b0); // beq
    add_vec(32'h00209063, 32'h3,        32'h4,      4'b0001, 32'h3,        32'h4,        1'b0); // bne
    add_vec(32'h0020D063, 32'h5,        32'h6,      EXP_BGE, 32'h5,        32'h6,        1'b0); // bge
    add_vec(32'h0020E063, 32'h5,        32'h6,      4'b0000, 32'h0,        32'h0,        1'b1); // bltu
    add_vec(32'h01F09093, 32'h1,        32'h99,     4'b0010, 32'h1,        32'd31,       1'b0); // slli 31
    add_vec(32'h0030D093, 32'hF0,       32'h99,     4'b0100, 32'hF0,       32'd3,        1'b0); // srli 3
    add_vec(32'h7FF0F093, 32'hABCD,     32'h99,     4'b0111, 32'hABCD,     32'h7FF,      1'b0); // andi 0x7ff
    add_vec(32'h8000C093, 32'h3,        32'h99,     4'b0011, 32'h3,        32'hFFFFF800, 1'b0); // xori -2048
    add_vec(32'h0000006F, 32'h12,       32'h34,     4'b0000, 32'h0,        32'h0,        1'b1); // jal
    add_vec(32'h0000B093, 32'h12,       32'h34,     4'b0000, 32'h0,        32'h0,        1'b1); // sltiu

    rst_n    = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    instr    = '0;
    rs1      = '0;
    rs2      = '0;
    cur_exp  = '0;

    // Values held while reset is asserted
    #3;
    checkOutput("rst_valid",   valid_out, 0);
    checkOutput("rst_ready",   ready_out, 0);
    checkOutput("rst_ctrl",    alu_ctrl,  0);
    checkOutput("rst_data1",   data1,     0);
    checkOutput("rst_data2",   data2,     0);
    checkOutput("rst_illegal", illegal,   0);
    #9 rst_n = 1'b1;
    tick();
    checkOutput("post_rst_ready", ready_out, 1);
    checkOutput("post_rst_valid", valid_out, 0);

    // Table sweep with the ALU always ready: each op appears one cycle after accept
    ready_in = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), valid_out, 1);
      checkOutput($sformatf("vec%0d_ctrl", i),  alu_ctrl,  vecs[i].ctrl);
      checkOutput($sformatf("vec%0d_data1", i), data1,     vecs[i].d1);
      checkOutput($sformatf("vec%0d_data2", i), data2,     vecs[i].d2);
      checkOutput($sformatf("vec%0d_ill", i),   illegal,   vecs[i].ill);
    end
    drain_all();
    tick();
    checkOutput("sweep_idle_valid", valid_out, 0);

    // Stall: three back-to-back offers with the ALU blocked, only two fit
    ready_in = 1'b0;
    applyStimulus(vecs[5]);
    tick();
    checkOutput("stall_c1_valid", valid_out, 1);
    checkOutput("stall_c2_ready", ready_out, 1);
    applyStimulus(vecs[6]);
    tick();
    checkOutput("stall_c3_ready", ready_out, 0);
    applyStimulus(vecs[7]);
    tick();
    checkOutput("stall_hold_ready", ready_out, 0);
    checkOutput("stall_hold_ctrl",  alu_ctrl,  vecs[5].ctrl);
    checkOutput("stall_hold_data1", data1,     vecs[5].d1);
    checkOutput("stall_hold_data2", data2,     vecs[5].d2);
    valid_in = 1'b0;
    ready_in = 1'b1;
    tick();
    checkOutput("stall_second_ctrl",  alu_ctrl, vecs[6].ctrl);
    checkOutput("stall_second_data1", data1,    vecs[6].d1);
    tick();
    checkOutput("stall_drained_valid", valid_out, 0);
    checkOutput("stall_sb_empty", sb.size(), 0);

    // Flush in FULL with a simultaneous offer
    ready_in = 1'b0;
    applyStimulus(vecs[8]);
    tick();
    applyStimulus(vecs[9]);
    tick();
    checkOutput("flushfull_pre_ready", ready_out, 0);
    applyStimulus(vecs[10]);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    valid_in = 1'b0;
    checkOutput("flushfull_valid", valid_out, 0);
    checkOutput("flushfull_ready", ready_out, 1);
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("flushfull_no_ghost", valid_out, 0);
    end

    // Flush in ONE while an offer would otherwise be accepted
    ready_in = 1'b0;
    applyStimulus(vecs[11]);
    tick();
    applyStimulus(vecs[12]);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    valid_in = 1'b0;
    checkOutput("flushone_valid", valid_out, 0);
    checkOutput("flushone_ready", ready_out, 1);
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("flushone_no_ghost", valid_out, 0);
    end

    // Asynchronous reset mid-cycle while one op is buffered
    ready_in = 1'b0;
    applyStimulus(vecs[2]);
    tick();
    valid_in = 1'b0;
    checkOutput("arst_pre_valid", valid_out, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid",   valid_out, 0);
    checkOutput("arst_ready",   ready_out, 0);
    checkOutput("arst_ctrl",    alu_ctrl,  0);
    checkOutput("arst_data1",   data1,     0);
    checkOutput("arst_data2",   data2,     0);
    checkOutput("arst_illegal", illegal,   0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    tick();
    checkOutput("arst_release_ready", ready_out, 1);
    ready_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("arst_no_leftover", valid_out, 0);
    end

    // Randomised traffic on both sides; ordering is checked by the scoreboard
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) != 0) applyStimulus(vecs[$urandom_range(0, vecs.size() - 1)]);
      else valid_in = 1'b0;
      ready_in = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain_all();
    tick();
    checkOutput("final_idle_valid", valid_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
